ps2_mouse_tracker: RTL and testbench

- Converts the PS/2 mouse byte stream into absolute, clamped screen coordinates and button states for the painting top level.
- Sits between the PS/2 byte receiver/init FSM inside the mouse controller and the top-level consumers of mouseX/mouseY/mouseLeftButton (pointer, canvas writes, GUI buttons).
- Assembles 3-byte standard PS/2 packets, sign-extends deltas, inverts Y to screen orientation, clamps to the visible area, and recovers from lost bytes.

---
 rtl/ps2_mouse_tracker.sv | 182 ++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// ps2_mouse_tracker
//
// Turns the PS/2 mouse byte stream into an absolute, clamped pointer position
// plus button states. Bytes are grouped into standard 3-byte packets. Each
// delta is sign-extended, Y is inverted so that 0 is the top of the screen,
// and the result is clamped to the visible area. If a packet stalls halfway,
// the partial packet is dropped and the tracker looks for a new header.
//
// Ports:
//   clk              system clock (100 MHz)
//   rst              asynchronous, active-high reset
//   stream_enable    mouse has acknowledged enable-reporting; bytes count only while high
//   rx_valid         one-cycle strobe per received byte
//   rx_byte          received byte, valid with rx_valid
//   mouseX           absolute X, 0..MAX_X
//   mouseY           absolute Y, 0..MAX_Y (0 = top)
//   mouseLeftButton  left button state
//   mouseRightButton right button state
//   packet_valid     one-cycle pulse when a packet has been applied
//   sync_error       one-cycle pulse on a rejected header byte or a timeout abort
// ---------------------------------------------------------------------------
module ps2_mouse_tracker #(
  parameter int MAX_X          = 639,
  parameter int MAX_Y          = 479,
  parameter int INIT_X         = 320,
  parameter int INIT_Y         = 240,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stream_enable,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [9:0] mouseX,
  output logic [9:0] mouseY,
  output logic       mouseLeftButton,
  output logic       mouseRightButton,
  output logic       packet_valid,
  output logic       sync_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [11:0] X_LIM = 12'(MAX_X);
  localparam logic signed [11:0] Y_LIM = 12'(MAX_Y);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  // Only the header bits that are used later are kept. Bit 3 is always 1
  // once a header has been accepted. Bit 2 is the middle button, which no
  // consumer uses.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic right;
    logic left;
  } hdr_t;

  state_t            state_q, state_d, cur_state;
  logic [CW-1:0]     cnt_q, cnt_d;
  hdr_t              hdr_q, hdr_d;
  logic [7:0]        dx_byte_q, dx_byte_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              left_q, left_d, right_q, right_d;
  logic              pv_q, pv_d, se_q, se_d;
  logic              timeout, accept;
  logic signed [11:0] dx_s, dy_s, x_sum, y_sum;
  logic              unused_middle_button;

  assign unused_middle_button = rx_byte[2];

  // The counter stays at 0 in WAIT_B0, so it can only expire mid-packet.
  assign timeout = (state_q != WAIT_B0) && (cnt_q >= CW'(TIMEOUT_CYCLES));

  // The Y delta comes straight from the third byte, so the packet is applied
  // in the same cycle as that byte's strobe.
  always_comb begin
    dx_s  = hdr_q.x_ovf ? '0 : {{4{hdr_q.x_sign}}, dx_byte_q};
    dy_s  = hdr_q.y_ovf ? '0 : {{4{hdr_q.y_sign}}, rx_byte};
    x_sum = $signed({2'b00, x_q}) + dx_s;
    y_sum = $signed({2'b00, y_q}) - dy_s;  // PS/2 +dy means up; screen Y grows downward
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // case/if tree can leave a value unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    dx_byte_d = dx_byte_q;
    x_d       = x_q;
    y_d       = y_q;
    left_d    = left_q;
    right_d   = right_q;
    pv_d      = 1'b0;
    se_d      = 1'b0;
    accept    = 1'b0;
    // A timeout in the same cycle as a byte makes that byte a header candidate.
    cur_state = timeout ? WAIT_B0 : state_q;

    if (!stream_enable) begin
      state_d = WAIT_B0;
    end else begin
      if (timeout) begin
        state_d = WAIT_B0;
        se_d    = 1'b1;
      end
      if (rx_valid) begin
        unique case (cur_state)
          WAIT_B0: begin
            if (rx_byte[3]) begin
              hdr_d   = hdr_t'({rx_byte[7:4], rx_byte[1:0]});
              state_d = WAIT_B1;
              accept  = 1'b1;
            end else begin
              se_d = 1'b1;
            end
          end
          WAIT_B1: begin
            dx_byte_d = rx_byte;
            state_d   = WAIT_B2;
            accept    = 1'b1;
          end
          WAIT_B2: begin
            state_d = WAIT_B0;
            accept  = 1'b1;
            pv_d    = 1'b1;
            left_d  = hdr_q.left;
            right_d = hdr_q.right;
            if (x_sum[11])          x_d = '0;
            else if (x_sum > X_LIM) x_d = 10'(MAX_X);
            else                    x_d = x_sum[9:0];
            if (y_sum[11])          y_d = '0;
            else if (y_sum > Y_LIM) y_d = 10'(MAX_Y);
            else                    y_d = y_sum[9:0];
          end
          default: state_d = WAIT_B0;
        endcase
      end
    end

    cnt_d = (accept || state_d == WAIT_B0) ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples its pre-edge value, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_B0;
      cnt_q     <= '0;
      hdr_q     <= '0;
      dx_byte_q <= '0;
      x_q       <= 10'(INIT_X);
      y_q       <= 10'(INIT_Y);
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      pv_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      dx_byte_q <= dx_byte_d;
      x_q       <= x_d;
      y_q       <= y_d;
      left_q    <= left_d;
      right_q   <= right_d;
      pv_q      <= pv_d;
      se_q      <= se_d;
    end
  end

  assign mouseX           = x_q;
  assign mouseY           = y_q;
  assign mouseLeftButton  = left_q;
  assign mouseRightButton = right_q;
  assign packet_valid     = pv_q;
  assign sync_error       = se_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_tracker
//
// Drives directed and randomized PS/2 packets into ps2_mouse_tracker. Each
// result is compared with an arithmetic model of the pointer: integer X/Y,
// clamped, with Y inverted. The timeout is shortened so the run stays short.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_tracker;

  localparam int T_OUT = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       stream_enable;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [9:0] mouseX, mouseY;
  logic       mouseLeftButton, mouseRightButton, packet_valid, sync_error;

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(T_OUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .stream_enable    (stream_enable),
    .rx_valid         (rx_valid),
    .rx_byte          (rx_byte),
    .mouseX           (mouseX),
    .mouseY           (mouseY),
    .mouseLeftButton  (mouseLeftButton),
    .mouseRightButton (mouseRightButton),
    .packet_valid     (packet_valid),
    .sync_error       (sync_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference pointer state
  int mx = 320, my = 240, ml = 0, mr = 0;

  // Pulse counters, sampled away from the active edge
  int pv_seen = 0, se_seen = 0;
  always @(negedge clk) begin
    if (packet_valid) pv_seen++;
    if (sync_error)   se_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; ml = 0; mr = 0;
  endtask

  task automatic model_apply(input logic [7:0] h, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = h[6] ? 0 : (h[4] ? int'(b1) - 256 : int'(b1));
    dy = h[7] ? 0 : (h[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dx, 639);
    my = clampi(my - dy, 479);
    ml = int'(h[0]);
    mr = int'(h[1]);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"}, int'(mouseX), mx);
    check({tag, "_y"}, int'(mouseY), my);
    check({tag, "_left"}, int'(mouseLeftButton), ml);
    check({tag, "_right"}, int'(mouseRightButton), mr);
  endtask

  // Returns on the falling edge after the edge that sampled the strobe.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 8)) @(negedge clk);
  endtask

  task automatic send_packet(input string tag, input logic [7:0] h,
                             input logic [7:0] b1, input logic [7:0] b2);
    send_byte(h);  gap();
    send_byte(b1); gap();
    send_byte(b2);
    model_apply(h, b1, b2);
    check({tag, "_pv_pulse"}, int'(packet_valid), 1);
    check_outputs(tag);
    @(negedge clk);
    check({tag, "_pv_end"}, int'(packet_valid), 0);
  endtask

  initial begin : stim
    int pv0, se0, waited, found;
    logic [7:0] h, b;

    rst = 1'b1; stream_enable = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle behaviour
    check_outputs("reset");
    check("reset_pv", int'(packet_valid), 0);
    check("reset_se", int'(sync_error), 0);
    pv0 = pv_seen; se0 = se_seen;
    repeat (3 * T_OUT) @(negedge clk);
    check("idle_pv_pulses", pv_seen - pv0, 0);
    check("idle_se_pulses", se_seen - se0, 0);
    check_outputs("idle");

    // Directed packets from the test plan, with absolute expectations too
    send_packet("p1", 8'h09, 8'h10, 8'h05);
    check("p1_abs_x", int'(mouseX), 336);
    check("p1_abs_y", int'(mouseY), 235);
    send_packet("p2", 8'h3A, 8'hF0, 8'hFB);
    check("p2_abs_x", int'(mouseX), 320);
    check("p2_abs_y", int'(mouseY), 240);

    // Clamp X high
    for (int i = 0; i < 3; i++) send_packet("xsat", 8'h08, 8'hFF, 8'h00);
    check("xsat_abs", int'(mouseX), 639);

    // Y to 400, then dy=-128 clamps at 479
    send_packet("y400", 8'h28, 8'h00, 8'h60);
    check("y400_abs", int'(mouseY), 400);
    send_packet("ysat_hi", 8'h28, 8'h00, 8'h80);
    check("ysat_hi_abs", int'(mouseY), 479);

    // Y down to 100, then dy=+255 clamps at 0
    send_packet("yup1", 8'h08, 8'h00, 8'hFF);
    send_packet("yup2", 8'h08, 8'h00, 8'h7C);
    check("y100_abs", int'(mouseY), 100);
    send_packet("ysat_lo", 8'h08, 8'h00, 8'hFF);
    check("ysat_lo_abs", int'(mouseY), 0);

    // Overflow: X frozen, Y still moves
    send_packet("y50", 8'h28, 8'h00, 8'hCE);
    send_packet("xovf", 8'h49, 8'h7F, 8'h01);
    check("xovf_abs_x", int'(mouseX), 639);
    check("xovf_abs_y", int'(mouseY), 49);

    // Rejected header
    send_byte(8'h00);
    check("bad_hdr_se", int'(sync_error), 1);
    check_outputs("bad_hdr");
    @(negedge clk);
    check("bad_hdr_se_end", int'(sync_error), 0);
    send_packet("after_bad", 8'h09, 8'h05, 8'h03);

    // Timeout mid-packet
    send_byte(8'h08);
    send_byte(8'h10);
    pv0 = pv_seen;
    waited = 0; found = 0;
    while (!found && waited < T_OUT + 100) begin
      @(negedge clk);
      waited++;
      if (sync_error) found = 1;
    end
    check("timeout_seen", found, 1);
    check("timeout_not_early", int'(waited >= T_OUT), 1);
    check("timeout_not_late", int'(waited <= T_OUT + 2), 1);
    check("timeout_no_pv", pv_seen - pv0, 0);
    check_outputs("timeout");
    send_packet("after_to", 8'h08, 8'h01, 8'h01);

    // stream_enable low drops the partial packet and ignores bytes silently
    send_byte(8'h08);
    @(negedge clk);
    stream_enable = 1'b0;
    pv0 = pv_seen; se0 = se_seen;
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h7F);
    check("dis_no_se", se_seen - se0, 0);
    check("dis_no_pv", pv_seen - pv0, 0);
    check_outputs("dis");
    stream_enable = 1'b1;
    send_packet("after_dis", 8'h1A, 8'hFE, 8'h02);

    // Randomized packets with occasional rejected headers
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = 8'($urandom) & 8'hF7;
        send_byte(b);
        check("rnd_bad_se", int'(sync_error), 1);
        check_outputs("rnd_bad");
      end else begin
        h = 8'($urandom) | 8'h08;
        send_packet("rnd", h, 8'($urandom), 8'($urandom));
      end
    end

    // Reset mid-packet: outputs return at once, asynchronously
    send_packet("pre_rst", 8'h08, 8'h05, 8'h05);
    send_byte(8'h08);
    send_byte(8'h20);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    send_packet("post_rst", 8'h09, 8'h02, 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
